// File: rtl/vga_scan_controller.sv
// VGA scan generator: a 2-clk pixel tick drives the scan counters, and a registered output
// stage composites the sprite/background colour, delayed one pixel, aligned with HS/VS/blank.
module vga_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] sprite_rgb,
  input  logic        sprite_visible,
  input  logic [23:0] bg_rgb,
  output logic [9:0]  pixelx,
  output logic [9:0]  pixely,
  output logic        frame_start,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        tick;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        frame_pend;
  logic        h_wrap;
  logic        v_wrap;
  logic        active;
  logic        hs_n;
  logic        vs_n;
  logic [23:0] pix_rgb;

  always_comb begin
    h_wrap  = (hcount == H_LAST);
    v_wrap  = (vcount == V_LAST);
    active  = (hcount < H_ACT) && (vcount < V_ACT);
    hs_n    = !((hcount >= HS_START) && (hcount < HS_END));
    vs_n    = !((vcount >= VS_START) && (vcount < VS_END));
    pix_rgb = 24'h000000;
    if (active) pix_rgb = sprite_visible ? sprite_rgb : bg_rgb;
  end

  // Pixel state moves on tick=1 edges; the tick=0 edge in between covers the sprite ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick        <= 1'b0;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      frame_pend  <= 1'b0;
      frame_start <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else begin
      tick        <= ~tick;
      // frame_start lands one clk after the counters reach (0,0), hence the pending stage.
      frame_pend  <= tick & h_wrap & v_wrap;
      frame_start <= frame_pend;
      if (tick) begin
        if (h_wrap) begin
          hcount <= 10'd0;
          vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
        vga_hs                <= hs_n;
        vga_vs                <= vs_n;
        vga_blank_n           <= active;
        {vga_r, vga_g, vga_b} <= pix_rgb;
      end
    end
  end

  assign pixelx     = hcount;
  assign pixely     = vcount;
  assign vga_clk    = tick;
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a full-size instance for line timing and compositing, and a
// miniature-geometry instance so whole frames fit in a short run.
module tb_vga_scan_controller;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  logic [23:0] d_srgb, d_bg, s_srgb, s_bg;
  logic        d_vis, s_vis;
  logic [9:0]  d_x, d_y, s_x, s_y;
  logic        d_fs, d_vclk, d_hs, d_vs, d_blank_n, d_sync_n;
  logic        s_fs, s_vclk, s_hs, s_vs, s_blank_n, s_sync_n;
  logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;

  vga_scan_controller dut_d (
    .clk(clk), .rst(rst), .sprite_rgb(d_srgb), .sprite_visible(d_vis), .bg_rgb(d_bg),
    .pixelx(d_x), .pixely(d_y), .frame_start(d_fs), .vga_clk(d_vclk), .vga_hs(d_hs),
    .vga_vs(d_vs), .vga_blank_n(d_blank_n), .vga_sync_n(d_sync_n),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  vga_scan_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .sprite_rgb(s_srgb), .sprite_visible(s_vis), .bg_rgb(s_bg),
    .pixelx(s_x), .pixely(s_y), .frame_start(s_fs), .vga_clk(s_vclk), .vga_hs(s_hs),
    .vga_vs(s_vs), .vga_blank_n(s_blank_n), .vga_sync_n(s_sync_n),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  // clock / reset
  always #10 clk = ~clk;

  // k = clk edges since reset release; pixel p = k/2 ticks have elapsed.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Stimulus colour for a coordinate: directed points on line 1 of the full instance, else a pattern.
  function automatic logic [48:0] stim(input bit full, input int x, input int y);
    logic        vis;
    logic [23:0] rgb;
    logic [23:0] bg;
    vis = ((x + y) % 3) != 0;
    rgb = {8'(x + 17), 8'(y * 3), 8'(x >> 2)};
    bg  = {8'h20, 8'(x), 8'h3C};
    if (full && y == 1) begin
      if (x == 100) begin vis = 1'b1; rgb = 24'hFF8000; bg = 24'h0000FF; end
      if (x == 101) begin vis = 1'b0; rgb = 24'hFF8000; bg = 24'h0000FF; end
      if (x == 700) begin vis = 1'b1; rgb = 24'hFFFFFF; bg = 24'h0000FF; end
    end
    return {vis, rgb, bg};
  endfunction

  // Expected outputs after k edges: coordinates = pixel k/2, outputs = decode of pixel k/2-1.
  function automatic exp_t model(input int kk, input bit full, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va, input int vfp,
                                 input int vsw, input int vbp);
    exp_t        e;
    int          ht, vt, fr, p, q, qx, qy;
    logic [48:0] st;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    fr = ht * vt;
    p  = kk / 2;
    e.x = 10'((p % fr) % ht);
    e.y = 10'((p % fr) / ht);
    e.vclk = (kk % 2) == 1;
    e.fs = (kk % 2 == 1) && (kk >= 3) && (((kk - 1) / 2) % fr == 0);
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.blank_n = 1'b0;
    e.rgb = 24'h0;
    if (kk >= 2) begin
      q  = p - 1;
      qx = (q % fr) % ht;
      qy = (q % fr) / ht;
      st = stim(full, qx, qy);
      e.hs = !(qx >= ha + hfp && qx < ha + hfp + hsw);
      e.vs = !(qy >= va + vfp && qy < va + vfp + vsw);
      e.blank_n = (qx < ha) && (qy < va);
      if (e.blank_n) e.rgb = st[48] ? st[47:24] : st[23:0];
    end
    return e;
  endfunction

  // driver: present the colour for the coordinates currently on the scan counters
  initial begin
    logic [48:0] sd, ss;
    int pd, ps;
    forever begin
      @(negedge clk);
      pd = (k / 2) % (800 * 525);
      ps = (k / 2) % (15 * 8);
      sd = stim(1'b1, pd % 800, pd / 800);
      ss = stim(1'b0, ps % 15, ps / 15);
      {d_vis, d_srgb, d_bg} = sd;
      {s_vis, s_srgb, s_bg} = ss;
    end
  end

  // scoreboard: compare both instances against the model on every falling edge
  initial begin
    exp_t ed, es;
    forever begin
      @(negedge clk);
      ed = model(k, 1'b1, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(k, 1'b0, 8, 2, 3, 2, 4, 1, 2, 1);
      check("d_pixelx", 32'(d_x), 32'(ed.x));
      check("d_pixely", 32'(d_y), 32'(ed.y));
      check("d_frame_start", 32'(d_fs), 32'(ed.fs));
      check("d_vga_clk", 32'(d_vclk), 32'(ed.vclk));
      check("d_hs", 32'(d_hs), 32'(ed.hs));
      check("d_vs", 32'(d_vs), 32'(ed.vs));
      check("d_blank_n", 32'(d_blank_n), 32'(ed.blank_n));
      check("d_rgb", 32'({d_r, d_g, d_b}), 32'(ed.rgb));
      check("d_sync_n", 32'(d_sync_n), 32'(0));
      check("s_pixelx", 32'(s_x), 32'(es.x));
      check("s_pixely", 32'(s_y), 32'(es.y));
      check("s_frame_start", 32'(s_fs), 32'(es.fs));
      check("s_vga_clk", 32'(s_vclk), 32'(es.vclk));
      check("s_hs", 32'(s_hs), 32'(es.hs));
      check("s_vs", 32'(s_vs), 32'(es.vs));
      check("s_blank_n", 32'(s_blank_n), 32'(es.blank_n));
      check("s_rgb", 32'({s_r, s_g, s_b}), 32'(es.rgb));
      check("s_sync_n", 32'(s_sync_n), 32'(0));
    end
  end

  task automatic wait_k(input int n);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (k != n && g < 5000);
    check("wait_k", 32'(k), 32'(n));
  endtask

  // directed vectors with hand-computed expectations
  initial begin
    #25 rst = 1'b0;
    wait_k(106);  check("s_blank_7_3", 32'(s_blank_n), 32'd1);
    wait_k(108);  check("s_blank_8_3", 32'(s_blank_n), 32'd0);
    wait_k(151);  check("s_vs_before", 32'(s_vs), 32'd1);
    wait_k(152);  check("s_vs_fall", 32'(s_vs), 32'd0);
    wait_k(211);  check("s_vs_last", 32'(s_vs), 32'd0);
    wait_k(212);  check("s_vs_rise", 32'(s_vs), 32'd1);
    wait_k(239);  check("s_x_last", 32'(s_x), 32'd14); check("s_y_last", 32'(s_y), 32'd7);
    wait_k(240);  check("s_x_wrap", 32'(s_x), 32'd0);  check("s_y_wrap", 32'(s_y), 32'd0);
                  check("s_fs_early", 32'(s_fs), 32'd0);
    wait_k(241);  check("s_fs_pulse", 32'(s_fs), 32'd1);
    wait_k(242);  check("s_fs_end", 32'(s_fs), 32'd0);
    wait_k(1280); check("d_blank_639", 32'(d_blank_n), 32'd1);
    wait_k(1282); check("d_blank_640", 32'(d_blank_n), 32'd0);
    wait_k(1312); check("d_x_656", 32'(d_x), 32'd656);
    wait_k(1313); check("d_hs_before", 32'(d_hs), 32'd1);
    wait_k(1314); check("d_hs_fall", 32'(d_hs), 32'd0);
    wait_k(1505); check("d_hs_last", 32'(d_hs), 32'd0);
    wait_k(1506); check("d_hs_rise", 32'(d_hs), 32'd1);
    wait_k(1599); check("d_x_799", 32'(d_x), 32'd799);
    wait_k(1600); check("d_x_wrap", 32'(d_x), 32'd0); check("d_y_1", 32'(d_y), 32'd1);
    wait_k(1802); check("d_rgb_sprite", 32'({d_r, d_g, d_b}), 32'hFF8000);
    wait_k(1804); check("d_rgb_bg", 32'({d_r, d_g, d_b}), 32'h0000FF);
    wait_k(3002); check("d_rgb_blanked", 32'({d_r, d_g, d_b}), 32'h0);
                  check("d_blank_700", 32'(d_blank_n), 32'd0);
    wait_k(3100);
    // asynchronous reset in the middle of the HS pulse
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_d_x", 32'(d_x), 32'd0);
    check("rst_d_y", 32'(d_y), 32'd0);
    check("rst_d_hs", 32'(d_hs), 32'd1);
    check("rst_d_vs", 32'(d_vs), 32'd1);
    check("rst_d_blank", 32'(d_blank_n), 32'd0);
    check("rst_d_rgb", 32'({d_r, d_g, d_b}), 32'h0);
    check("rst_d_vclk", 32'(d_vclk), 32'd0);
    check("rst_s_x", 32'(s_x), 32'd0);
    check("rst_s_fs", 32'(s_fs), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_k(1);   check("rel_x0", 32'(d_x), 32'd0);
    wait_k(2);   check("rel_x1", 32'(d_x), 32'd1); check("rel_hs", 32'(d_hs), 32'd1);
    wait_k(4);   check("rel_x2", 32'(d_x), 32'd2);
    wait_k(241); check("rel_s_fs", 32'(s_fs), 32'd1);
    wait_k(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
